// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, FAULT} fetch_state_t;
endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding request/grant fetch per slot, valid/ready
// output register to decode, flush handling and misaligned-PC fault capture.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = INSTR_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic            slot_free;
  logic            misaligned;

  // Issue needs a free output slot so the response can always be loaded on arrival.
  assign slot_free  = !id_valid || id_ready;
  assign misaligned = pc_in[1:0] != 2'b00;
  assign imem_req   = !reset && !flush && (state == IDLE) && slot_free && !misaligned;
  assign pc_advance = imem_req && imem_gnt;
  assign imem_addr  = pc_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc_q     <= '0;
      id_valid <= 1'b0;
      id_fault <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      // An un-returned response must still be swallowed before issuing again.
      if (state == WAIT || state == DRAIN)
        state <= imem_rvalid ? IDLE : DRAIN;
      else
        state <= IDLE;
    end else begin
      if (id_valid && id_ready) id_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (slot_free && misaligned) begin
            id_valid <= 1'b1;
            id_fault <= 1'b1;
            id_instr <= NOP;
            id_pc    <= pc_in;
            state    <= FAULT;
          end else if (pc_advance) begin
            pc_q  <= pc_in;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            id_valid <= 1'b1;
            id_fault <= 1'b0;
            id_instr <= imem_rdata;
            id_pc    <= pc_q;
            state    <= IDLE;
          end
        end
        DRAIN: if (imem_rvalid) state <= IDLE;
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed per-cycle vector table, reset-mid-WAIT
// sequence, and randomized traffic against a transaction-level reference model.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset, flush, imem_gnt, imem_rvalid, id_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_advance, imem_req, id_valid, id_fault;
  logic [31:0] imem_addr, id_instr, id_pc;

  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_advance(pc_advance),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, rd, gn, rv, input logic [31:0] pc, data);
    flush = fl; id_ready = rd; imem_gnt = gn; imem_rvalid = rv;
    pc_in = pc; imem_rdata = data;
  endtask

  typedef struct {
    logic        fl, rd, gn, rv;
    logic [31:0] pc, data;
    logic        req, adv, v, f;
    logic [31:0] opc, oins;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic fl, rd, gn, rv, input logic [31:0] pc, data,
                     input logic req, adv, v, f, input logic [31:0] opc, oins);
    vec_t t;
    t = '{fl, rd, gn, rv, pc, data, req, adv, v, f, opc, oins};
    vq.push_back(t);
  endtask

  typedef struct { int due; logic [31:0] pc, data; } rsp_t;
  rsp_t q[$];

  initial begin
    logic        m_v, m_f, locked, want, exp_req, exp_adv, fl, rd, gn, rv;
    logic [31:0] m_pc, m_ins, cur_pc, data;
    int          cyc;

    // Reset: combinational outputs must stay low even with a grantable request.
    reset = 1'b1;
    drive(0, 1, 1, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req", imem_req, 0);
    chk("rst_adv", pc_advance, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_fault", id_fault, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc", id_pc, 0);
    reset = 1'b0;

    // fl rd gn rv pc data | req adv | v f opc oins (after edge)
    add(0,1,1,0, 32'h0,   32'h0,        1,1, 0,0, 0, 0);           // stream
    add(0,1,1,1, 32'h4,   32'hA000_0000, 0,0, 1,0, 32'h0, 32'hA000_0000);
    add(0,1,1,0, 32'h4,   32'h0,        1,1, 0,0, 0, 0);
    add(0,1,1,1, 32'h8,   32'hA000_0004, 0,0, 1,0, 32'h4, 32'hA000_0004);
    for (int i = 0; i < 5; i++)                                      // decode stall
      add(0,0,1,0, 32'h8, 32'h0,        0,0, 1,0, 32'h4, 32'hA000_0004);
    add(0,1,1,0, 32'h8,   32'h0,        1,1, 0,0, 0, 0);           // release: issue pc=8
    add(1,1,1,0, 32'h100, 32'h0,        0,0, 0,0, 0, 0);           // flush in WAIT
    add(0,1,1,0, 32'h100, 32'h0,        0,0, 0,0, 0, 0);           // DRAIN
    add(0,1,1,1, 32'h100, 32'hDEAD_BEEF, 0,0, 0,0, 0, 0);          // late data dropped
    add(0,1,1,0, 32'h100, 32'h0,        1,1, 0,0, 0, 0);
    add(0,1,1,1, 32'h104, 32'hB000_0100, 0,0, 1,0, 32'h100, 32'hB000_0100);
    add(0,1,1,0, 32'h104, 32'h0,        1,1, 0,0, 0, 0);
    add(1,1,1,1, 32'h104, 32'hC000_0000, 0,0, 0,0, 0, 0);          // flush + rvalid
    add(0,1,1,0, 32'h6,   32'h0,        0,0, 1,1, 32'h6, 32'h13);  // misaligned
    add(0,1,1,0, 32'h6,   32'h0,        0,0, 0,0, 0, 0);           // stuck in FAULT
    add(0,0,1,0, 32'h6,   32'h0,        0,0, 0,0, 0, 0);
    add(1,1,1,0, 32'h200, 32'h0,        0,0, 0,0, 0, 0);           // flush out
    add(0,1,1,0, 32'h200, 32'h0,        1,1, 0,0, 0, 0);
    add(0,1,0,1, 32'h204, 32'hD000_0200, 0,0, 1,0, 32'h200, 32'hD000_0200);
    add(0,1,0,0, 32'h204, 32'h0,        1,0, 0,0, 0, 0);           // req without gnt
    add(0,1,1,0, 32'h204, 32'h0,        1,1, 0,0, 0, 0);           // now in WAIT

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].rd, vq[i].gn, vq[i].rv, vq[i].pc, vq[i].data);
      #4;
      chk($sformatf("v%0d_req", i), imem_req, vq[i].req);
      chk($sformatf("v%0d_adv", i), pc_advance, vq[i].adv);
      if (vq[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vq[i].pc);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), id_valid, vq[i].v);
      if (vq[i].v) begin
        chk($sformatf("v%0d_fault", i), id_fault, vq[i].f);
        chk($sformatf("v%0d_pc", i), id_pc, vq[i].opc);
        chk($sformatf("v%0d_instr", i), id_instr, vq[i].oins);
      end
    end

    // Reset mid-WAIT beats flush and rvalid.
    reset = 1'b1;
    drive(1, 1, 1, 1, 32'h208, 32'hFFFF_FFFF);
    #4;
    chk("rw_req", imem_req, 0);
    chk("rw_adv", pc_advance, 0);
    @(posedge clk); #1;
    chk("rw_valid", id_valid, 0);
    chk("rw_fault", id_fault, 0);
    chk("rw_instr", id_instr, 0);
    chk("rw_pc", id_pc, 0);
    reset = 1'b0;
    drive(0, 1, 1, 0, 32'h300, 32'h0);
    #4;
    chk("rw_idle_req", imem_req, 1);
    chk("rw_idle_adv", pc_advance, 1);
    @(posedge clk); #1;
    drive(0, 1, 0, 1, 32'h304, 32'hE000_0300);
    @(posedge clk); #1;
    chk("rw_resume_valid", id_valid, 1);
    chk("rw_resume_pc", id_pc, 32'h300);
    chk("rw_resume_instr", id_instr, 32'hE000_0300);

    // Randomized phase against a transaction-level model.
    reset = 1'b1;
    drive(0, 1, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_v = 0; m_f = 0; m_pc = 0; m_ins = 0; locked = 0; want = 0;
    cur_pc = 32'h1000;
    for (cyc = 0; cyc < 3000; cyc++) begin
      fl = ($urandom % 100) < 6;
      rd = ($urandom % 100) < 70;
      gn = ($urandom % 100) < 60;
      rv = (q.size() > 0) && (q[0].due == cyc);
      data = rv ? q[0].data : $urandom;
      drive(fl, rd, gn, rv, cur_pc, data);
      // Idle means nothing outstanding at the memory and not parked on a fault.
      exp_req = !fl && q.size() == 0 && !locked && (!m_v || rd) && cur_pc[1:0] == 2'b00;
      exp_adv = exp_req && gn;
      #4;
      chk("rnd_req", imem_req, exp_req);
      chk("rnd_adv", pc_advance, exp_adv);
      if (exp_req) chk("rnd_addr", imem_addr, cur_pc);
      @(posedge clk); #1;
      if (fl) begin
        m_v = 0; locked = 0; want = 0;
        if (rv) void'(q.pop_front());
        cur_pc = ($urandom & 32'h0000_FFFC) | ((($urandom % 6) == 0) ? 32'h2 : 32'h0);
      end else begin
        if (m_v && rd) m_v = 0;
        if (q.size() == 0 && !locked && (!m_v || rd) && cur_pc[1:0] != 2'b00 && !m_v) begin
          m_v = 1; m_f = 1; m_ins = 32'h13; m_pc = cur_pc; locked = 1;
        end else if (exp_adv) begin
          q.push_back('{cyc + $urandom_range(1, 3), cur_pc, $urandom});
          want = 1;
          cur_pc = cur_pc + 4;
        end
        if (rv) begin
          if (want) begin
            m_v = 1; m_f = 0; m_ins = q[0].data; m_pc = q[0].pc;
          end
          want = 0;
          void'(q.pop_front());
        end
      end
      chk("rnd_valid", id_valid, m_v);
      if (m_v) begin
        chk("rnd_fault", id_fault, m_f);
        chk("rnd_pc", id_pc, m_pc);
        chk("rnd_instr", id_instr, m_ins);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
